// File: rtl/ariane_pkg.sv
// Core-level types: scoreboard tag width and the buffered CSR operation
// record held between issue and commit.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = riscv::TRANS_ID_BITS;

  typedef struct packed {
    logic [11:0]              addr;
    riscv::xlen_t             wdata;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } csr_buf_entry_t;

endpackage

// File: rtl/riscv_pkg.sv
// Base ISA types shared by the execution units: register width and
// the operand bundle handed from issue to each functional unit.
package riscv;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t                     operand_a;
    xlen_t                     operand_b;
    logic [TRANS_ID_BITS-1:0]  trans_id;
  } fu_data_t;

endpackage

// File: rtl/csr_multi_buffer.sv
// In-order buffer of CSR operations issued ahead of commit. The head entry
// is presented to the CSR file and retired when commit acknowledges it.
module csr_multi_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  riscv::fu_data_t            fu_data_i,
  input  logic                       csr_valid_i,
  output logic                       csr_ready_o,
  output riscv::xlen_t               csr_result_o,
  input  logic                       csr_commit_i,
  output logic [11:0]                csr_addr_o,
  output riscv::xlen_t               csr_wdata_o,
  output logic [TRANS_ID_BITS-1:0]   csr_trans_id_o,
  output logic                       csr_head_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] csr_count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  csr_buf_entry_t   mem_q [DEPTH];
  csr_buf_entry_t   mem_d [DEPTH];

  csr_buf_entry_t   new_entry;
  csr_buf_entry_t   head_entry;
  logic             push;
  logic             pop;
  logic             unused_operand_b;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign new_entry.addr     = fu_data_i.operand_b[11:0];
  assign new_entry.wdata    = fu_data_i.operand_a;
  assign new_entry.trans_id = fu_data_i.trans_id;
  assign unused_operand_b   = ^fu_data_i.operand_b[riscv::XLEN-1:12];

  assign csr_result_o = fu_data_i.operand_a;

  always_comb begin
    csr_ready_o = (count_q < DEPTH_C) || csr_commit_i;
    push        = csr_valid_i && csr_ready_o;
    pop         = csr_commit_i && (count_q != '0);
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      // When full, a push lands in the head slot that the same-cycle pop frees.
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (!push && pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_entry       = mem_q[rd_ptr_q];
  assign csr_head_valid_o = (count_q != '0);
  assign csr_count_o      = count_q;
  assign csr_addr_o       = csr_head_valid_o ? head_entry.addr : '0;
  assign csr_wdata_o      = csr_head_valid_o ? head_entry.wdata : '0;
  assign csr_trans_id_o   = csr_head_valid_o ? TRANS_ID_BITS'(head_entry.trans_id) : '0;

`ifndef SYNTHESIS
  // Both events are legal and handled, but worth flagging when they occur.
  cover property (@(posedge clk_i) disable iff (!rst_ni) csr_commit_i && (count_q == '0));
  cover property (@(posedge clk_i) disable iff (!rst_ni) csr_valid_i && !csr_ready_o);
  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_csr_multi_buffer.sv
// Self-checking bench: DEPTH=2 and DEPTH=3 buffers share one stimulus stream
// and are compared against queue-based reference models every cycle.
module tb_csr_multi_buffer;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            csr_valid_i;
  logic            csr_commit_i;
  riscv::fu_data_t fu_data_i;

  logic         d2_ready, d3_ready;
  riscv::xlen_t d2_result, d3_result;
  logic [11:0]  d2_addr, d3_addr;
  riscv::xlen_t d2_wdata, d3_wdata;
  logic [2:0]   d2_tid, d3_tid;
  logic         d2_hv, d3_hv;
  logic [1:0]   d2_count, d3_count;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [2:0]  tid;
  } ent_t;

  ent_t q2[$];
  ent_t q3[$];
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk_i = ~clk_i;

  csr_multi_buffer #(.DEPTH(2)) u_d2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fu_data_i(fu_data_i),
    .csr_valid_i(csr_valid_i), .csr_ready_o(d2_ready), .csr_result_o(d2_result),
    .csr_commit_i(csr_commit_i), .csr_addr_o(d2_addr), .csr_wdata_o(d2_wdata),
    .csr_trans_id_o(d2_tid), .csr_head_valid_o(d2_hv), .csr_count_o(d2_count)
  );

  csr_multi_buffer #(.DEPTH(3)) u_d3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fu_data_i(fu_data_i),
    .csr_valid_i(csr_valid_i), .csr_ready_o(d3_ready), .csr_result_o(d3_result),
    .csr_commit_i(csr_commit_i), .csr_addr_o(d3_addr), .csr_wdata_o(d3_wdata),
    .csr_trans_id_o(d3_tid), .csr_head_valid_o(d3_hv), .csr_count_o(d3_count)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_inst(input string name, input int depth, input int sz, input ent_t head,
                            input logic rdy, input logic hv, input logic [1:0] cnt,
                            input logic [11:0] addr, input logic [63:0] wd,
                            input logic [2:0] tid, input logic [63:0] res);
    check_output({name, "_ready"}, 64'(rdy), 64'((sz < depth) || csr_commit_i));
    check_output({name, "_head_valid"}, 64'(hv), 64'(sz > 0));
    check_output({name, "_count"}, 64'(cnt), 64'(sz));
    check_output({name, "_addr"}, 64'(addr), 64'(head.addr));
    check_output({name, "_wdata"}, wd, head.wdata);
    check_output({name, "_trans_id"}, 64'(tid), 64'(head.tid));
    check_output({name, "_result"}, res, fu_data_i.operand_a);
  endtask

  task automatic check_all();
    ent_t h2;
    ent_t h3;
    h2 = '{addr: '0, wdata: '0, tid: '0};
    h3 = '{addr: '0, wdata: '0, tid: '0};
    if (q2.size() > 0) h2 = q2[0];
    if (q3.size() > 0) h3 = q3[0];
    check_inst("d2", 2, q2.size(), h2, d2_ready, d2_hv, d2_count, d2_addr, d2_wdata, d2_tid, d2_result);
    check_inst("d3", 3, q3.size(), h3, d3_ready, d3_hv, d3_count, d3_addr, d3_wdata, d3_tid, d3_result);
  endtask

  // Reference behaviour at a clock edge: flush wins, otherwise retire then append.
  task automatic model_edge();
    ent_t e;
    bit   acc2;
    bit   acc3;
    e    = '{addr: fu_data_i.operand_b[11:0], wdata: fu_data_i.operand_a, tid: fu_data_i.trans_id};
    acc2 = (q2.size() < 2) || csr_commit_i;
    acc3 = (q3.size() < 3) || csr_commit_i;
    if (flush_i) begin
      q2.delete();
      q3.delete();
    end else begin
      if (csr_commit_i && q2.size() > 0) void'(q2.pop_front());
      if (csr_commit_i && q3.size() > 0) void'(q3.pop_front());
      if (csr_valid_i && acc2) q2.push_back(e);
      if (csr_valid_i && acc3) q3.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic c, input logic f,
                                input logic [63:0] opa, input logic [11:0] addr,
                                input logic [2:0] tid);
    @(negedge clk_i);
    csr_valid_i         = v;
    csr_commit_i        = c;
    flush_i             = f;
    fu_data_i.operand_a = opa;
    fu_data_i.operand_b = {$urandom, 20'($urandom), addr};
    fu_data_i.trans_id  = tid;
    #1;
    check_all();
    @(posedge clk_i);
    model_edge();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    csr_valid_i  = 1'b0;
    csr_commit_i = 1'b0;
    fu_data_i    = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_output("rst_hold_ready", 64'(d2_ready), 64'd1);
    check_output("rst_hold_count", 64'(d2_count), 64'd0);
    rst_ni = 1'b1;
    #1;
    check_output("rst_ready", 64'(d2_ready), 64'd1);
    check_output("rst_head_valid", 64'(d2_hv), 64'd0);
    check_output("rst_count", 64'(d2_count), 64'd0);
    check_output("rst_addr", 64'(d2_addr), 64'd0);

    // Fill DEPTH=2, then a refused third push.
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'hA0, 12'h300, 3'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'hA1, 12'h341, 3'd2);
    #2;
    check_output("fill_count", 64'(d2_count), 64'd2);
    check_output("fill_head", 64'(d2_addr), 64'h300);
    check_output("fill_ready", 64'(d2_ready), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'hA2, 12'h123, 3'd3);
    #2;
    check_output("refused_count", 64'(d2_count), 64'd2);
    check_output("refused_head", 64'(d2_addr), 64'h300);

    // Full bypass: push with commit while full.
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'hA3, 12'h180, 3'd4);
    #2;
    check_output("bypass_count", 64'(d2_count), 64'd2);
    check_output("bypass_head", 64'(d2_addr), 64'h341);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hA4, 12'h000, 3'd0);
    #2;
    check_output("bypass_head2", 64'(d2_addr), 64'h180);

    // Flush overrides a same-cycle push and commit.
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'hA5, 12'h200, 3'd5);
    apply_stimulus(1'b1, 1'b1, 1'b1, 64'hA6, 12'h7C0, 3'd6);
    #2;
    check_output("flush_count", 64'(d2_count), 64'd0);
    check_output("flush_head_valid", 64'(d2_hv), 64'd0);
    check_output("flush_count_d3", 64'(d3_count), 64'd0);

    // Commit while empty is ignored; the push still lands.
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 12'h001, 3'd7);
    #2;
    check_output("empty_commit_count", 64'(d2_count), 64'd1);
    check_output("empty_commit_head", 64'(d2_addr), 64'h001);
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'h0, 12'h000, 3'd0);

    // Pointer wrap: each push retired one cycle later.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, i > 0, 1'b0, rnd64(), 12'h310 + 12'(i), 3'(i));
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, rnd64(), 12'h000, 3'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, rnd64(), 12'h000, 3'd0);

    // Reset in mid-stream discards everything.
    apply_stimulus(1'b1, 1'b0, 1'b0, rnd64(), 12'h3A0, 3'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, rnd64(), 12'h3A1, 3'd2);
    @(negedge clk_i);
    csr_valid_i  = 1'b0;
    csr_commit_i = 1'b0;
    rst_ni       = 1'b0;
    #1;
    check_output("midrst_count_d2", 64'(d2_count), 64'd0);
    check_output("midrst_count_d3", 64'(d3_count), 64'd0);
    check_output("midrst_head_valid", 64'(d3_hv), 64'd0);
    check_output("midrst_ready", 64'(d2_ready), 64'd1);
    q2.delete();
    q3.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom % 100) < 60, ($urandom % 100) < 45, ($urandom % 100) < 4,
                     rnd64(), 12'($urandom), 3'($urandom));
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, rnd64(), 12'h000, 3'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/csr_multi_buffer.md
CSR_MULTI_BUFFER -- requirements
Module: csr_multi_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of outstanding CSR ops held; legal range 1..8, any integer.
REQ-002 SHALL have parameter TRANS_ID_BITS, default ariane_pkg::TRANS_ID_BITS, scoreboard tag width.
REQ-003 SHALL have port clk_i  input  1  clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all buffered entries.
REQ-006 SHALL have port fu_data_i  input  riscv::fu_data_t  issue data; operand_a = write data, operand_b[11:0] = CSR address, trans_id = tag.
REQ-007 SHALL have port csr_valid_i  input  1  issue request valid.
REQ-008 SHALL have port csr_ready_o  output  1  buffer can accept an issue this cycle.
REQ-009 SHALL have port csr_result_o  output  riscv::xlen_t  writeback value to scoreboard.
REQ-010 SHALL have port csr_commit_i  input  1  commit stage retires the head entry.
REQ-011 SHALL have port csr_addr_o  output  12  head entry CSR address.
REQ-012 SHALL have port csr_wdata_o  output  riscv::xlen_t  head entry write data.
REQ-013 SHALL have port csr_trans_id_o  output  TRANS_ID_BITS  head entry tag.
REQ-014 SHALL have port csr_head_valid_o  output  1  head entry present.
REQ-015 SHALL have port csr_count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL implement an in-order FIFO of DEPTH entries {addr[11:0], wdata, trans_id}.
REQ-017 SHALL push when csr_valid_i && csr_ready_o: addr = operand_b[11:0], wdata = operand_a, trans_id = fu_data_i.trans_id.
REQ-018 SHALL drive csr_ready_o = (count < DEPTH) || csr_commit_i, i.e. full + commit in the same cycle accepts a push.
REQ-019 SHALL drive csr_result_o = fu_data_i.operand_a combinationally, zero latency.
REQ-020 SHALL drive csr_addr_o, csr_wdata_o, csr_trans_id_o from the head entry register with no combinational path from the issue inputs; all are 0 while empty.
REQ-021 SHALL pop the head on csr_commit_i when count > 0; commit while empty is ignored and state is unchanged.
REQ-022 SHALL, on simultaneous push and pop with count > 0, leave count unchanged and move the head to the next entry.
REQ-023 SHALL, on a push into an empty buffer with commit asserted, ignore the commit and set count to 1.
REQ-024 SHALL wrap read and write pointers from DEPTH-1 to 0, for non-power-of-two DEPTH as well.
REQ-025 SHALL, on flush_i, set count to 0 and both pointers to 0 next cycle, overriding any same-cycle push or pop.
REQ-026 SHALL update count, pointers and entries only on the rising edge of clk_i.

Reset
REQ-027 SHALL, while rst_ni = 0, hold count = 0, pointers = 0 and all entry fields = 0, giving csr_head_valid_o = 0, csr_count_o = 0 and csr_ready_o = 1.
REQ-028 SHALL discard any operation in flight when reset asserts mid-stream; the first cycle after deassertion behaves as empty.

Structure
REQ-029 SHALL place the entry struct type (csr_buf_entry_t) in ariane_pkg, sized by TRANS_ID_BITS and riscv::XLEN.
REQ-030 SHALL be implemented without a sub-module: one register array plus a pointer/count block.
REQ-031 SHALL carry an assertion (non-synthesis) flagging csr_commit_i while empty, and csr_valid_i while not ready.

Verification
REQ-032 Reset: rst_ni = 0 for 3 cycles, then 1 -> csr_ready_o = 1, csr_head_valid_o = 0, csr_count_o = 0, csr_addr_o = 0.
REQ-033 Fill, DEPTH = 2: push addr 0x300 then 0x341, no commit -> count = 2, ready = 0, head addr = 0x300; a third push is refused while commit = 0.
REQ-034 Full bypass: full {0x300, 0x341}; push 0x180 together with commit -> next cycle count = 2, head = 0x341; commit again -> head = 0x180.
REQ-035 Wrap, DEPTH = 3: 7 pushes each followed one cycle later by a commit -> head addr, wdata and trans_id sequence match the pushes in order across pointer wrap.
REQ-036 Flush: count = 2, and in the same cycle flush_i = 1 with push 0x7C0 and commit -> next cycle count = 0, head_valid = 0, the 0x7C0 entry is absent.
REQ-037 Empty commit: count = 0, commit = 1 and push 0x001 in the same cycle -> count = 1, head addr = 0x001, and csr_result_o equals operand_a in that same cycle.
